// File: rtl/decoder_sweep_sequencer_pkg.sv
// Shared types and helpers for the decoder sweep sequencer.
// The state encoding is fixed so that existing consumers of the state bits still decode it.
package decoder_pkg;

    localparam int SEL_W_DEF = 6;
    localparam int NUM_OUT   = 64;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'b00;
    localparam state_t SWEEP = 2'b01;
    localparam state_t DONE  = 2'b10;

    // Modulo increment: 63 wraps to 0.
    function automatic logic [SEL_W_DEF-1:0] next_idx(input logic [SEL_W_DEF-1:0] idx);
        return idx + SEL_W_DEF'(1);
    endfunction

endpackage

// File: rtl/decoder_sweep_sequencer_if.sv
// Control and decoder-drive bundle between the sweep controller and the sequencer.
interface decoder_sweep_sequencer_if
    import decoder_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = 4,
    parameter int CNT_W   = SEL_W + 1
);
    logic               start;
    logic               abort;
    logic [SEL_W-1:0]   start_idx;
    logic [SEL_W-1:0]   end_idx;
    logic [DWELL_W-1:0] dwell;
    logic               busy;
    logic               done;
    logic               seq_en;
    logic [SEL_W-1:0]   seq_sel;
    logic [CNT_W-1:0]   step_cnt;

    modport master (
        output start, abort, start_idx, end_idx, dwell,
        input  busy, done, seq_en, seq_sel, step_cnt
    );

    modport slave (
        input  start, abort, start_idx, end_idx, dwell,
        output busy, done, seq_en, seq_sel, step_cnt
    );
endinterface

// File: rtl/decoder_sweep_sequencer_dwell.sv
// Per-index dwell counter: counts 1..eff_dwell and flags the terminal count.
module sweep_dwell_counter #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               en,
    input  logic [DWELL_W-1:0] eff_dwell,
    output logic               expire
);
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    assign expire = en && (cnt_q >= eff_dwell);

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = DWELL_W'(1);
        else if (en && !expire)
            cnt_d = cnt_q + DWELL_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/decoder_sweep_sequencer.sv
// Sweeps the 6-to-64 decoder select over a programmable, wrapping index range
// with a per-index dwell, under a start/busy/done/abort handshake.
module decoder_sweep_sequencer
    import decoder_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = 4,
    parameter int CNT_W   = SEL_W + 1
) (
    input  logic clk,
    input  logic rst,
    decoder_sweep_sequencer_if.slave bus
);
    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   end_q, end_d;
    logic [DWELL_W-1:0] eff_q, eff_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load, expire, cnt_en;

    assign cnt_en = (state_q == SWEEP);

    sweep_dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .en        (cnt_en),
        .eff_dwell (eff_q),
        .expire    (expire)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        end_d   = end_q;
        eff_d   = eff_q;
        step_d  = step_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = SWEEP;
                    sel_d   = bus.start_idx;
                    end_d   = bus.end_idx;
                    eff_d   = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
                    step_d  = CNT_W'(1);
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            SWEEP: begin
                // Abort takes priority over a coinciding final expiry.
                if (bus.abort) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (expire) begin
                    if (sel_q == end_q) begin
                        state_d = DONE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        sel_d  = next_idx(sel_q);
                        step_d = step_q + CNT_W'(1);
                        load   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            end_q   <= '0;
            eff_q   <= '0;
            step_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            end_q   <= end_d;
            eff_q   <= eff_d;
            step_q  <= step_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.seq_en   = en_q;
    assign bus.seq_sel  = sel_q;
    assign bus.step_cnt = step_q;
endmodule

// File: doc/decoder_sweep_sequencer.md
Name: decoder_sweep_sequencer

Overview:
Upstream driver for the 6-to-64 decoder stage. Generates its enable and 6-bit select, sweeping an index range. Range is programmable, each index is held for a programmable number of cycles, and wrap-around through 63→0 is supported. Start/busy/done handshake with the controlling logic; abort supported.

Parameters:
SEL_W, 6, select width; decoder has 2**SEL_W outputs
DWELL_W, 4, width of per-index dwell count
CNT_W, 7, width of step counter (SEL_W+1, holds 2**SEL_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  sweep request, sampled only in IDLE
start_idx  input  SEL_W  first index issued
end_idx  input  SEL_W  last index issued
dwell  input  DWELL_W  cycles each index is held (0 treated as 1)
abort  input  1  terminate sweep, no done pulse
busy  output  1  high while sweeping
done  output  1  one-cycle pulse after last index completes
seq_en  output  1  drives decoder_en
seq_sel  output  SEL_W  drives decoder_in
step_cnt  output  CNT_W  indices issued in current/last sweep

Behaviour:
- Reset, asynchronous, applied immediately, including mid-sweep:
  - state=IDLE
  - busy=0, done=0, seq_en=0, seq_sel=0, step_cnt=0
  - internal dwell counter=0
- All outputs are registered. No combinational input-to-output paths.
- States are IDLE, SWEEP and DONE.
- IDLE:
  - seq_en=0.
  - seq_sel and step_cnt hold their last values.
  - If start=1 at edge k, latch start_idx, end_idx and eff_dwell=max(dwell,1).
  - After edge k: state=SWEEP, seq_sel=start_idx, seq_en=1, busy=1, step_cnt=1, dwell counter=1.
- SWEEP:
  - The current index is held while dwell counter < eff_dwell; the counter increments each cycle.
  - At expiry with seq_sel==latched end_idx: go to DONE, seq_en=0, busy=0.
  - At expiry otherwise: seq_sel = (seq_sel+1) mod 2**SEL_W, step_cnt+=1, dwell counter=1.
  - Wrap: when end_idx < start_idx the sweep passes 63→0.
  - start_idx==end_idx issues one index.
  - start_idx==end_idx+1 (mod 64) issues all 64 indices, final step_cnt=64.
- DONE: done=1 for exactly one cycle, seq_en=0, then IDLE unconditionally.
- start while busy or in DONE is ignored. Inputs are not relatched mid-sweep; changes to start_idx/end_idx/dwell during a sweep have no effect.
- abort=1 in SWEEP: next state is IDLE, seq_en=0, busy=0, no done pulse. step_cnt and seq_sel hold.
- abort on the same edge as dwell expiry of the last index: abort wins, no done.
- abort in IDLE or DONE is ignored; a DONE pulse still completes.
- start and abort together in IDLE: start accepted, abort ignored.
- Timing:
  - Total sweep length is N×eff_dwell cycles of seq_en=1, where N = ((end_idx−start_idx) mod 64)+1.
  - done is asserted on the cycle right after seq_en falls.
- seq_en and seq_sel change on the same edge. The downstream decoder output is one-hot on bit seq_sel whenever seq_en=1.

Decomposition:
- Shared package decoder_pkg holds:
  - State typedef: IDLE=2'b00, SWEEP=2'b01, DONE=2'b10. The 2'b11 encoding recovers to IDLE.
  - Constants SEL_W_DEF=6 and NUM_OUT=64.
  - Function next_idx(idx), the modulo increment.
- One natural sub-module, sweep_dwell_counter:
  - Inputs load, eff_dwell. Output expire.
  - Counts 1..eff_dwell and asserts expire at the terminal count.
- The FSM, index register and step counter stay in the top.

Test Plan:
- rst=1 mid-sweep (start_idx=10, end_idx=20, dwell=2, reset at cycle 7) → outputs go to 0 the same cycle. After release, IDLE and seq_en=0 until the next start.
- start_idx=0, end_idx=63, dwell=1 → seq_sel=0..63, one per cycle, seq_en=1 for 64 cycles. done pulses once the cycle after. step_cnt=64. Decoder output walks bit 0→63.
- start_idx=60, end_idx=3, dwell=3 → sequence 60,61,62,63,0,1,2,3, each held 3 cycles (24 cycles). step_cnt=8, one done.
- start_idx=5, end_idx=5, dwell=0 → seq_sel=5 for exactly 1 cycle, step_cnt=1, done next cycle.
- Sweep 0→15, dwell=2:
  - abort on cycle 9 → seq_en drops next edge, no done, step_cnt=5, seq_sel=4.
  - start pulsed at cycle 4 of the sweep → ignored, sequence unchanged.
- Back-to-back sweeps, start held high through DONE → second sweep begins only after IDLE is re-entered (one idle cycle with seq_en=0 between sweeps).
